// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR filter chain.
// fir_filter also uses the width constants from this package.
package fir_pkg;

    localparam int FIR_IN_W  = 20;
    localparam int FIR_OUT_W = 8;
    localparam int FIR_DECIM = 4;
    localparam int FIR_SHIFT = 12;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_t;

    // Half an output LSB, added before the shift to round half-up.
    function automatic logic [31:0] fir_round_const(input int shift);
        return 32'd1 << (shift - 1);
    endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// Output-side valid/ready stream of fir_decimator.
interface fir_decimator_if
    import fir_pkg::*;
#(
    parameter int OUT_W = FIR_OUT_W
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_out_fifo.sv
// Two-entry in-order output buffer; slot0 is always the head.
// A push into a full buffer with no pop is discarded and flagged on drop.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int W = FIR_OUT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic         drop
);

    fifo_state_t  state_r, state_s;
    logic [W-1:0] slot0_r, slot0_s;
    logic [W-1:0] slot1_r, slot1_s;
    logic         valid_r, valid_s;
    logic         pop_s;
    logic         drop_s;

    // Next occupancy and slot contents; an empty slot is held at zero.
    always_comb begin
        state_s = state_r;
        slot0_s = slot0_r;
        slot1_s = slot1_r;
        drop_s  = 1'b0;
        pop_s   = valid_r && pop_ready;
        case (state_r)
            FIFO_EMPTY: begin
                if (push) begin
                    slot0_s = push_data;
                    state_s = FIFO_ONE;
                end else begin
                    state_s = FIFO_EMPTY;
                end
            end
            FIFO_ONE: begin
                if (push && pop_s) begin
                    slot0_s = push_data;
                end else if (push) begin
                    slot1_s = push_data;
                    state_s = FIFO_FULL;
                end else if (pop_s) begin
                    slot0_s = {W{1'b0}};
                    state_s = FIFO_EMPTY;
                end else begin
                    state_s = FIFO_ONE;
                end
            end
            FIFO_FULL: begin
                if (push && pop_s) begin
                    slot0_s = slot1_r;
                    slot1_s = push_data;
                end else if (pop_s) begin
                    slot0_s = slot1_r;
                    slot1_s = {W{1'b0}};
                    state_s = FIFO_ONE;
                end else if (push) begin
                    drop_s  = 1'b1;
                end else begin
                    state_s = FIFO_FULL;
                end
            end
            default: begin
                state_s = FIFO_EMPTY;
                slot0_s = {W{1'b0}};
                slot1_s = {W{1'b0}};
            end
        endcase
        valid_s = (state_s != FIFO_EMPTY);
    end

    // State and slot registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= FIFO_EMPTY;
            slot0_r <= {W{1'b0}};
            slot1_r <= {W{1'b0}};
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            slot0_r <= slot0_s;
            slot1_r <= slot1_s;
            valid_r <= valid_s;
        end
    end

    assign head_data  = slot0_r;
    assign head_valid = valid_r;
    assign drop       = drop_s;

endmodule

// File: rtl/fir_decimator.sv
// Keeps every DECIM-th valid sample, requantizes it to OUT_W bits and buffers it.
// Define FIR_DEC_ROUND_EN for round-half-up; the default build truncates.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int DECIM = FIR_DECIM,
    parameter int SHIFT = FIR_SHIFT
) (
    input  logic                   CLK_Filter,
    input  logic                   rst_n,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_valid,
    output logic                   ovf,
    input  logic                   ovf_clr,
    fir_decimator_if.master        out_if
);

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
`ifdef FIR_DEC_ROUND_EN
    localparam logic [IN_W:0] RND_C = (IN_W + 1)'(fir_round_const(SHIFT));
`else
    localparam logic [IN_W:0] RND_C = {(IN_W + 1){1'b0}};
`endif

    logic [PH_W-1:0]  phase_r, phase_s;
    logic             keep_s;
    logic [IN_W:0]    sum_s;
    logic [IN_W:0]    shifted_s;
    logic             sat_s;
    logic [OUT_W-1:0] quant_s;
    logic [OUT_W-1:0] q_data_r;
    logic             q_valid_r;
    logic             ovf_r;
    logic             drop_s;
    logic [OUT_W-1:0] fifo_data_s;
    logic             fifo_valid_s;

    // Phase advance and keep decision.
    always_comb begin
        keep_s = in_valid && (phase_r == {PH_W{1'b0}});
        if (in_valid) begin
            phase_s = (phase_r == PH_LAST) ? {PH_W{1'b0}} : phase_r + PH_W'(1);
        end else begin
            phase_s = phase_r;
        end
    end

    // Requantizer: one extra sum bit so the rounding carry is never lost.
    always_comb begin
        sum_s     = {1'b0, in_data} + RND_C;
        shifted_s = sum_s >> SHIFT;
        sat_s     = (shifted_s >> OUT_W) != {(IN_W + 1){1'b0}};
        if (sat_s) begin
            quant_s = {OUT_W{1'b1}};
        end else begin
            quant_s = shifted_s[OUT_W-1:0];
        end
    end

    // Phase counter, quantizer register and sticky overflow; a fresh drop beats a clear.
    always_ff @(posedge CLK_Filter) begin
        if (!rst_n) begin
            phase_r   <= {PH_W{1'b0}};
            q_data_r  <= {OUT_W{1'b0}};
            q_valid_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            phase_r   <= phase_s;
            q_valid_r <= keep_s;
            if (keep_s) begin
                q_data_r <= quant_s;
            end else begin
                q_data_r <= q_data_r;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    fir_out_fifo #(
        .W (OUT_W)
    ) u_fifo (
        .clk        (CLK_Filter),
        .rst_n      (rst_n),
        .push       (q_valid_r),
        .push_data  (q_data_r),
        .pop_ready  (out_if.out_ready),
        .head_data  (fifo_data_s),
        .head_valid (fifo_valid_s),
        .drop       (drop_s)
    );

    assign out_if.out_data  = fifo_data_s;
    assign out_if.out_valid = fifo_valid_s;
    assign ovf              = ovf_r;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator with a queue scoreboard and a handshake monitor.
module tb_fir_decimator;
    import fir_pkg::*;

`ifdef FIR_DEC_ROUND_EN
    localparam int EXP_2048 = 1;
`else
    localparam int EXP_2048 = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] in_data;
    logic        in_valid;
    logic        ovf;
    logic        ovf_clr;

    fir_decimator_if #(.OUT_W(FIR_OUT_W)) bus ();

    fir_decimator dut (
        .CLK_Filter (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .out_if     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int ph = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One input cycle; kept samples that are not expected to be dropped go on the scoreboard.
    task automatic drive(input int d, input int exp, input bit drop, input bit rdy);
        in_valid      = 1'b1;
        in_data       = 20'(d);
        bus.out_ready = rdy;
        ovf_clr       = 1'b0;
        if (ph == 0 && !drop) sb.push_back(exp);
        ph = (ph + 1) % 4;
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit rdy, input bit clr);
        in_valid      = 1'b0;
        bus.out_ready = rdy;
        ovf_clr       = clr;
        @(posedge clk); #1;
        ovf_clr       = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 40) begin
            idle(1'b1, 1'b0);
            n++;
        end
        check("drain_done", (sb.size() == 0 && !bus.out_valid), 1);
    endtask

    task automatic monitor();
        bit             held = 1'b0;
        logic [7:0]     held_data = 8'd0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (held) begin
                    check("stall_valid", bus.out_valid, 1);
                    check("stall_data", bus.out_data, held_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", bus.out_data, 32'hFFFF_FFFF);
                    end else begin
                        check("out_data", bus.out_data, sb.pop_front());
                    end
                end
                held      = bus.out_valid && !bus.out_ready;
                held_data = bus.out_data;
            end else begin
                held = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 20'd0; ovf_clr = 1'b0; bus.out_ready = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        // Ramp: one output per four inputs, two-cycle latency.
        for (int i = 0; i < 24; i++) begin
            drive(i * 4096, i, 1'b0, 1'b1);
            if (i == 0) check("lat_early", bus.out_valid, 0);
            if (i == 1) begin
                check("lat_valid", bus.out_valid, 1);
                check("lat_data", bus.out_data, 0);
            end
        end
        drain();

        // Rounding and saturation.
        repeat (4) drive(2048, EXP_2048, 1'b0, 1'b1);
        repeat (4) drive(2047, 0, 1'b0, 1'b1);
        repeat (4) drive(20'hFFFFF, 255, 1'b0, 1'b1);
        repeat (4) drive(20'hFF800, 255, 1'b0, 1'b1);
        drain();

        // Backpressure: two buffered, later kept samples dropped.
        for (int c = 0; c < 20; c++) drive(4096 * (c / 4 + 1), c / 4 + 1, (c / 4) >= 2, 1'b0);
        check("bp_ovf_set", ovf, 1);
        check("bp_head_valid", bus.out_valid, 1);
        check("bp_head_data", bus.out_data, 1);
        for (int c = 20; c < 28; c++) drive(4096 * (c / 4 + 1), c / 4 + 1, 1'b0, 1'b1);
        check("ovf_sticky", ovf, 1);
        idle(1'b1, 1'b1);
        check("ovf_cleared", ovf, 0);
        drain();

        // Full FIFO with push and pop on the same edge.
        for (int c = 0; c < 12; c++) drive(4096 * (10 + c / 4), 10 + c / 4, 1'b0, c == 9);
        check("pp_no_ovf", ovf, 0);
        check("pp_head", bus.out_data, 11);
        drain();

        // Reset while full and overflowed.
        for (int c = 0; c < 12; c++) drive(4096 * (13 + c / 4), 13 + c / 4, c >= 8, 1'b0);
        check("pre_rst_ovf", ovf, 1);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 20'(4096 * 20); bus.out_ready = 1'b0;
        sb.delete();
        ph = 0;
        @(posedge clk); #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_data", bus.out_data, 0);
        check("mid_rst_ovf", ovf, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(8192, 2, 1'b0, 1'b1);
            if (c == 1) begin
                check("post_rst_valid", bus.out_valid, 1);
                check("post_rst_data", bus.out_data, 2);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Output stage placed directly downstream of `fir_filter`. Consumes the 20-bit unsigned `filter_out` stream, keeps every DECIM-th sample, and requantizes each kept sample to OUT_W bits (right shift, optional rounding, saturation). Kept samples leave through a 2-entry valid/ready output buffer with a sticky overflow flag. Lets a slower consumer (DAC/UART framer) take filtered data without the filter needing backpressure.

## Interface
- `IN_W`, 20: input sample width; matches `filter_out`.
- `OUT_W`, 8: output sample width.
- `DECIM`, 4: decimation factor, ≥1; a `DECIM` of 1 keeps every sample.
- `SHIFT`, 12: right shift applied before saturation, 1 ≤ SHIFT < IN_W.
- `CLK_Filter`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_data`  in  IN_W  unsigned sample, wired to `filter_out`.
- `in_valid`  in  1  sample present this cycle; tie high when driven by `fir_filter`.
- `out_data`  out  OUT_W  FIFO head sample; 0 when empty.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head this cycle.
- `ovf`  out  1  sticky: a kept sample was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `ovf`. A new drop in the same cycle wins.

## Operation
- Phase counter counts 0..DECIM-1 and advances only on `in_valid`, wrapping at DECIM-1 back to 0.
- A sample is kept when `in_valid` is high and the phase is 0. The first valid sample after reset is therefore kept.
- Requantize:
  - Form an (IN_W+1)-bit sum: `in_data` plus the rounding constant (2^(SHIFT-1) with rounding, 0 without).
  - Shift the sum right by SHIFT.
  - If the result exceeds 2^OUT_W−1, output all ones; otherwise output the low OUT_W bits.
- The quantizer register (`q_data`, `q_valid`) captures each kept sample. The next cycle, `q_valid` pushes `q_data` into the FIFO.
- FIFO: 2 entries, in order.
  - Pop when `out_valid && out_ready`.
  - Push and pop in the same cycle are always allowed, including when full: the pop frees the slot.
  - Push while full with no pop: the sample is discarded, FIFO contents are unchanged, and `ovf` is set.
- The pop side is a standard valid/ready handshake. `out_data` and `out_valid` must stay stable while `out_valid && !out_ready`.

## Timing
- Reset (`rst_n` low at an edge): phase=0, q_valid=0, FIFO empty, `out_valid`=0, `out_data`=0, `ovf`=0.
- Reset asserted mid-operation discards all in-flight and buffered samples the same edge. No output is produced from pre-reset data.
- Latency: a sample kept at edge k is in the quantizer register after edge k and appears at the FIFO head with `out_valid`=1 after edge k+1. That is 2 cycles from `in_data` to `out_data` when the FIFO was empty.
- Throughput: one kept sample per DECIM valid inputs. With `out_ready` held high the FIFO never holds more than 1 entry.
- `ovf` rises on the edge following the dropped push and holds until `ovf_clr` or reset.

## Configuration
- `FIR_DEC_ROUND_EN` defined: rounding constant 2^(SHIFT-1), i.e. round-half-up.
- `FIR_DEC_ROUND_EN` undefined: rounding constant 0, i.e. truncation. Saturation is present in both builds.

## Structure
- Shared package `fir_pkg`:
  - width constants `FIR_IN_W=20` and `FIR_OUT_W=8`, also used by `fir_filter`;
  - default `FIR_DECIM` and `FIR_SHIFT`;
  - a function returning the rounding constant for a given SHIFT.
- One sub-module, `fir_out_fifo`, holds the 2-entry FIFO: push/pop/full/empty logic, with a drop output that drives `ovf`.
- `fir_decimator` holds the phase counter, the quantizer and the `ovf` register.

## Test plan
All scenarios use default parameters unless stated.
1. Decimation: drive a ramp `in_data`=0,4096,8192,… on consecutive cycles with `out_ready`=1 -> outputs 0,4,8,12,…, one every 4 cycles. The first output is valid 2 cycles after the first input.
2. Rounding: drive constant 2048, then constant 2047 -> 1 then 0 with `FIR_DEC_ROUND_EN`; 0 then 0 without.
3. Saturation: drive 20'hFFFFF -> 255 in both builds. Drive 20'h0FF800 -> 255 with rounding, 255 without; no wrap to 0.
4. Backpressure: constant 4096, `out_ready`=0 for 20 cycles.
   - The FIFO holds two 1's.
   - The third kept sample sets `ovf`.
   - Releasing `out_ready` yields exactly the buffered samples, then the stream resumes.
   - `ovf_clr` clears the flag.
5. Full plus simultaneous push/pop: with the FIFO full, assert `out_ready` on the cycle a kept sample pushes -> no drop, `ovf` stays 0, order preserved.
6. Reset mid-stream: drop `rst_n` for 1 cycle while the FIFO holds 2 samples and `in_valid`=1 -> `out_valid`=0, `out_data`=0, `ovf`=0 after the edge. The first valid input after release is kept (phase 0).
